// File: rtl/conv_psum_accum.sv
// Partial-sum accumulator for a column of three 3x3 conv PEs: adds the three row sums,
// accumulates over num_pass channel passes and holds the pixel result on a valid/ready register.
module conv_psum_accum #(
  parameter int PSUM_W = 18,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] psum0,
  input  logic [PSUM_W-1:0] psum1,
  input  logic [PSUM_W-1:0] psum2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  num_pass,
  input  logic              clear,
  output logic              busy,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              state_dbg
);

  // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
  // a result transfers on a rising clk edge where out_valid && out_ready.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q;
  logic [OUT_W-1:0]   acc_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   pass_cnt_q;
  logic [CNT_W-1:0]   np_lat_q;

  logic [OUT_W-1:0]   sum3;
  logic [OUT_W-1:0]   acc_d;
  logic [CNT_W-1:0]   np_eff;
  logic               accept;
  logic               last_beat;

  assign sum3 = OUT_W'(psum0) + OUT_W'(psum1) + OUT_W'(psum2);

  // A programmed count of zero behaves as a single pass.
  assign np_eff = (num_pass == '0) ? CNT_W'(1) : num_pass;

  assign in_ready  = !(out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready && !clear;
  assign last_beat = (state_q == IDLE) ? (np_eff == CNT_W'(1))
                                       : (pass_cnt_q == np_lat_q - CNT_W'(1));
  assign acc_d     = (state_q == IDLE) ? sum3 : acc_q + sum3;

  assign busy      = (state_q == ACCUM);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pass_cnt_q  <= '0;
      np_lat_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (clear) begin
        state_q    <= IDLE;
        acc_q      <= '0;
        pass_cnt_q <= '0;
      end else if (accept) begin
        if (state_q == IDLE) begin
          np_lat_q <= np_eff;
        end
        if (last_beat) begin
          state_q    <= IDLE;
          acc_q      <= '0;
          pass_cnt_q <= '0;
        end else begin
          state_q    <= ACCUM;
          acc_q      <= acc_d;
          pass_cnt_q <= pass_cnt_q + CNT_W'(1);
        end
      end

      // A new result may replace one being consumed on the same edge.
      if (accept && last_beat) begin
        out_data_q  <= acc_d;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_psum_accum.md
Name: conv_psum_accum

Overview:
- Downstream of a column of three 3x3 conv PEs.
- Each cycle the three PEs each produce an 18-bit unsigned row partial sum (one 1x3 dot product per kernel row).
- This block adds the three row sums into a full 3x3 window result, then accumulates that result over a programmable number of input-channel passes.
- It presents the final output-pixel psum on a one-entry valid/ready output register to the ofmap writer.

Parameters:
- PSUM_W, 18: width of each incoming PE partial sum.
- OUT_W, 32: width of the accumulator and output. Must be >= PSUM_W+2.
- CNT_W, 8: width of the pass counter and of num_pass.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- psum0  in  PSUM_W  kernel row 0 partial sum (top PE OUT)
- psum1  in  PSUM_W  kernel row 1 partial sum
- psum2  in  PSUM_W  kernel row 2 partial sum
- in_valid  in  1  psum0..2 valid this cycle
- in_ready  out  1  block accepts a beat this cycle
- num_pass  in  CNT_W  channel passes per output pixel; sampled on the first beat of a group
- clear  in  1  synchronous abort of the group in progress
- busy  out  1  a group is partially accumulated
- out_data  out  OUT_W  accumulated output-pixel psum
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer takes out_data

Behaviour:
- Reset: all outputs and internal state are asynchronously forced as follows.
  - acc=0, pass_cnt=0, np_lat=0.
  - out_data=0, out_valid=0, busy=0, state=IDLE.
  - in_ready is combinational; it is 1 while in reset-release idle.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = !(out_valid && !out_ready). The block stalls only while a held result is unconsumed.
- sum3 = psum0+psum1+psum2, zero-extended to OUT_W. The three inputs are unsigned.
- States:
  - IDLE: no partial group.
  - ACCUM: 1 <= pass_cnt < np_lat.
- IDLE, beat accepted:
  - np_lat <= (num_pass==0 ? 1 : num_pass).
  - If the effective count is 1, the result goes straight to output (see "Final beat" below) and the state stays IDLE.
  - Otherwise acc <= sum3, pass_cnt <= 1, and the state moves to ACCUM.
- ACCUM, beat accepted:
  - If pass_cnt == np_lat-1, this is the final beat (see below).
  - Otherwise acc <= acc+sum3 and pass_cnt++.
- num_pass changes mid-group are ignored; only np_lat governs the group.
- Final beat:
  - out_data <= acc+sum3, or sum3 when it is the first beat.
  - out_valid <= 1 on the next edge. Latency is 1 cycle from the final accepted beat to out_valid.
  - acc <= 0, pass_cnt <= 0, state returns to IDLE.
- Output handshake:
  - out_valid falls on the edge where out_valid && out_ready, unless a new final beat is accepted that same edge. In that case out_data is replaced and out_valid stays 1.
  - Full throughput: num_pass=1 with out_ready held 1 gives one result per cycle.
- Arithmetic: the accumulator wraps modulo 2^OUT_W. There is no saturation and no overflow flag.
- busy = (state==ACCUM).
- clear:
  - Takes priority over a beat in the same cycle. That beat is dropped and is not accumulated.
  - acc <= 0, pass_cnt <= 0, state <= IDLE.
  - A pending out_data/out_valid is not affected.
- Stall: while in_ready=0 no beat is accepted. The upstream holds psum0..2 and in_valid, and acc/pass_cnt do not change.
- Reset mid-group or with a held result: everything returns to the reset values immediately and the held result is lost.
- Inputs with in_valid=0 are ignored; X on psum is allowed then.

Test Plan:
- num_pass=1, out_ready=1, beat psum=(10,20,30) -> out_valid=1 with out_data=60 on the next cycle; 4 back-to-back beats give 4 consecutive results.
- num_pass=3, beats (1,2,3),(100,200,300),(195075,195075,195075) -> single result 585831 after the 3rd beat; busy=1 after beats 1-2, busy=0 after beat 3.
- Backpressure: out_ready=0, two num_pass=1 beats -> first result held, in_ready=0 and the second beat stalls; raising out_ready -> first result consumed, second accepted, out_data updated the next cycle.
- clear asserted with the 2nd beat of a num_pass=3 group -> that beat is dropped, busy=0; a new num_pass=2 group (5,5,5),(1,1,1) -> out_data=18.
- OUT_W=20, num_pass=2, beats (195075,195075,195075) twice -> out_data=(1170450 mod 2^20)=121874.
- rst pulsed mid-group and again while out_valid=1 -> out_valid=0, busy=0, out_data=0 immediately; the next num_pass=0 beat (7,0,0) is treated as num_pass=1 -> out_data=7.
